// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit that owns the architectural HI/LO registers.
// Optional build macro MDU_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module mul_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic              hi_we_i,
   input  logic              lo_we_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);
   // state   | meaning
   // S_IDLE  | accepts start and MTHI/MTLO writes
   // S_CALC  | one multiply or divide iteration per clock, 32 in total
   // S_FIXUP | applies sign correction, writes HI/LO, pulses done
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIXUP = 2'd2} state_t;

   localparam logic [5:0] LAST_ITER = 6'd31;

   state_t              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   m_q, m_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic                done_q, done_d;

   logic                op_signed;
   logic [DATA_W-1:0]   abs_a, abs_b;
   logic [DATA_W:0]     mul_sum, rem_sh;
   logic [2*DATA_W-1:0] mul_step, div_step, mul_res;
   logic                q_bit;
   logic [DATA_W-1:0]   rem_new, quo, rem, quo_fix, rem_fix;

   assign op_signed = ~op_i[0];
   assign abs_a     = (op_signed && rs_data_i[DATA_W-1]) ? -rs_data_i : rs_data_i;
   assign abs_b     = (op_signed && rt_data_i[DATA_W-1]) ? -rt_data_i : rt_data_i;

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, m_q};
   assign mul_step = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};

   // Restoring divide: remainder in the high half, dividend shifts out as quotient shifts in.
   assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
   assign q_bit    = (rem_sh >= {1'b0, m_q});
   assign rem_new  = q_bit ? (rem_sh[DATA_W-1:0] - m_q) : rem_sh[DATA_W-1:0];
   assign div_step = {rem_new, acc_q[DATA_W-2:0], q_bit};

   assign mul_res = neg_q ? -acc_q : acc_q;
   assign quo     = acc_q[DATA_W-1:0];
   assign rem     = acc_q[2*DATA_W-1:DATA_W];
   // A zero divisor leaves the remainder equal to |rs|; re-signing restores the raw rs bits.
   assign quo_fix = dz_q ? {DATA_W{1'b1}} : (neg_q ? -quo : quo);
   assign rem_fix = rneg_q ? -rem : rem;

`ifdef MDU_FAST_MUL_EN
   logic [2*DATA_W-1:0] fast_prod;
   assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hi_we_i) hi_d = wr_data_i;
            if (lo_we_i) lo_d = wr_data_i;
            if (start_i) begin
               div_d  = op_i[1];
               cnt_d  = '0;
               neg_d  = op_signed & (rs_data_i[DATA_W-1] ^ rt_data_i[DATA_W-1]);
               rneg_d = op_signed & op_i[1] & rs_data_i[DATA_W-1];
               dz_d   = op_i[1] & (rt_data_i == '0);
               if (op_i[1]) begin
                  acc_d = {{DATA_W{1'b0}}, abs_a};
                  m_d   = abs_b;
               end else begin
                  acc_d = {{DATA_W{1'b0}}, abs_b};
                  m_d   = abs_a;
               end
               state_d = S_CALC;
`ifdef MDU_FAST_MUL_EN
               if (!op_i[1]) begin
                  acc_d   = fast_prod;
                  state_d = S_FIXUP;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = div_q ? div_step : mul_step;
            if (cnt_q == LAST_ITER) begin
               cnt_d   = '0;
               state_d = S_FIXUP;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_FIXUP: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = mul_res[2*DATA_W-1:DATA_W];
               lo_d = mul_res[DATA_W-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected {hi,lo} against an arithmetic model.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mul_div_unit;
   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] rs = '0, rt = '0, wr_data = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   mul_div_unit #(.DATA_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
      .rs_data_i(rs), .rt_data_i(rt), .hi_we_i(hi_we), .lo_we_i(lo_we),
      .wr_data_i(wr_data), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
   );

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      int          ia, ib, q, m;
      logic [63:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ia = a;
      ib = b;
      r  = '0;
      case (o)
         2'd0: r = sa * sb;
         2'd1: r = {32'h0, a} * {32'h0, b};
         2'd2: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else begin
               q = ia / ib;
               m = ia % ib;
               r = {m, q};
            end
         end
         default: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   function automatic int lat_for(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
      return o[1] ? 33 : 1;
`else
      return 33;
`endif
   endfunction

   // Called just after a negedge; returns 1 time unit after the accepting edge.
   task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
      start = 1'b1; op = o; rs = a; rt = b;
      if (push) sb_q.push_back(model(o, a, b));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int          lat;
      bit          seen;
      logic [63:0] exp;
      lat = 0; seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) lat++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: done not seen within 200 cycles", name);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: done seen with no expected result queued", name);
      end else begin
         exp = sb_q.pop_front();
         if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
         end
         if (exp_lat >= 0) begin
            checks++;
            if (lat != exp_lat) begin
               errors++;
               $display("FAIL %s latency: got %0d busy cycles, expected %0d", name, lat, exp_lat);
            end
         end
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("reset_hi", hi, 32'h0);
      check_val("reset_lo", lo, 32'h0);
      check_val("reset_busy", {31'h0, busy}, 32'h0);
      check_val("reset_done", {31'h0, done}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_mult_basic;
      @(negedge clk);
      drive_op(2'd0, 32'hFFFFFFFE, 32'h3, 1'b1);
      wait_done("mult_basic", lat_for(2'd0));
      check_val("mult_basic_hi", hi, 32'hFFFFFFFF);
      check_val("mult_basic_lo", lo, 32'hFFFFFFFA);
      @(negedge clk);
      check_val("done_single_pulse", {31'h0, done}, 32'h0);
   endtask

   task automatic test_mul_corners;
      @(negedge clk); drive_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_done("multu_max", lat_for(2'd1));
      check_val("multu_max_hi", hi, 32'hFFFFFFFE);
      @(negedge clk); drive_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_done("mult_m1", lat_for(2'd0));
      @(negedge clk); drive_op(2'd0, 32'h80000000, 32'h80000000, 1'b1); wait_done("mult_minint", lat_for(2'd0));
      @(negedge clk); drive_op(2'd0, 32'h0, 32'h12345678, 1'b1); wait_done("mult_zero", lat_for(2'd0));
   endtask

   task automatic test_div;
      @(negedge clk); drive_op(2'd2, 32'hFFFFFFF9, 32'h2, 1'b1); wait_done("div_neg7_2", lat_for(2'd2));
      check_val("div_neg7_2_lo", lo, 32'hFFFFFFFD);
      @(negedge clk); drive_op(2'd3, 32'h7, 32'h2, 1'b1); wait_done("divu_7_2", lat_for(2'd3));
      @(negedge clk); drive_op(2'd2, 32'h7, 32'hFFFFFFFE, 1'b1); wait_done("div_7_neg2", lat_for(2'd2));
      @(negedge clk); drive_op(2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1); wait_done("div_neg7_neg2", lat_for(2'd2));
   endtask

   task automatic test_div_corners;
      @(negedge clk); drive_op(2'd3, 32'h7, 32'h0, 1'b1); wait_done("divu_by_zero", lat_for(2'd3));
      check_val("divu_by_zero_lo", lo, 32'hFFFFFFFF);
      @(negedge clk); drive_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done("div_overflow", lat_for(2'd2));
      check_val("div_overflow_lo", lo, 32'h80000000);
      @(negedge clk); drive_op(2'd2, 32'hFFFFFFFB, 32'h0, 1'b1); wait_done("div_neg_by_zero", lat_for(2'd2));
      @(negedge clk); drive_op(2'd3, 32'h5, 32'h9, 1'b1); wait_done("divu_small", lat_for(2'd3));
   endtask

   task automatic test_back_to_back;
      @(negedge clk); drive_op(2'd0, 32'd123, 32'hFFFFFFFC, 1'b1);
      wait_done("b2b_first", lat_for(2'd0));
      drive_op(2'd3, 32'd1000, 32'd3, 1'b1);
      wait_done("b2b_second", lat_for(2'd3));
   endtask

   task automatic test_mt_write;
      @(negedge clk); lo_we = 1'b1; wr_data = 32'hCAFE;
      @(posedge clk); #1 lo_we = 1'b0;
      @(negedge clk);
      check_val("mtlo_idle", lo, 32'hCAFE);
      hi_we = 1'b1; wr_data = 32'hBEEF;
      drive_op(2'd3, 32'h7, 32'h2, 1'b1);
      hi_we = 1'b0;
      @(negedge clk);
      check_val("mthi_with_start", hi, 32'hBEEF);
      wait_done("divu_after_mthi", lat_for(2'd3) - 1);
   endtask

   task automatic test_busy_ignore;
      @(negedge clk); drive_op(2'd3, 32'd100, 32'd7, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'd0; rs = 32'h2; rt = 32'h2; hi_we = 1'b1; wr_data = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      @(negedge clk);
      check_val("mthi_while_busy", hi, 32'h1);
      wait_done("divu_100_7", -1);
      repeat (3) @(negedge clk);
      check_val("no_relaunch_busy", {31'h0, busy}, 32'h0);
      hi_we = 1'b1; wr_data = 32'h1234;
      @(posedge clk); #1 hi_we = 1'b0;
      @(negedge clk);
      check_val("mthi_idle_hi", hi, 32'h1234);
      check_val("mthi_idle_lo", lo, 32'd14);
   endtask

   task automatic test_reset_midop;
      @(negedge clk); drive_op(2'd0, 32'd5, 32'd5, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midreset_hi", hi, 32'h0);
      check_val("midreset_lo", lo, 32'h0);
      check_val("midreset_busy", {31'h0, busy}, 32'h0);
      check_val("midreset_done", {31'h0, done}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk); drive_op(2'd1, 32'd5, 32'd5, 1'b1);
      wait_done("multu_after_reset", lat_for(2'd1));
   endtask

   task automatic test_random;
      logic [1:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
         @(negedge clk); drive_op(o, a, b, 1'b1);
         wait_done("random", lat_for(o));
      end
   endtask

   initial begin
      test_reset;
      test_mult_basic;
      test_mul_corners;
      test_div;
      test_div_corners;
      test_back_to_back;
      test_mt_write;
      test_busy_ignore;
      test_reset_midop;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits downstream of the general-purpose register file: consumes the rs/rt read ports for MULT, MULTU, DIV and DIVU.
- HI/LO outputs feed the MFHI/MFLO writeback mux back into the register file.
- Multi-cycle: the control unit stalls the PC while busy=1.

Parameters:
DATA_W, 32, operand/HI/LO width; only 32 is supported, so the counter width is fixed at 6 bits.

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  32  operand A (multiplicand / dividend)
rt_data  input  32  operand B (multiplier / divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wr_data  input  32  data for MTHI/MTLO
busy  output  1  operation in flight; stall request
done  output  1  one-cycle pulse when HI/LO are updated
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset=0 (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: start=1 at edge E0 latches op, |operands| (signed ops) or raw operands (unsigned ops), and result signs; -> CALC; busy=1 after E0.
  - CALC: one iteration per edge, E1..E32; 6-bit counter 0..31; at counter=31 -> FIXUP.
  - FIXUP: at E33 apply sign correction, write hi/lo, busy=0, done=1 for exactly one cycle; -> IDLE.
- Latency: 33 edges from accept to result visible. A new start is accepted at E33's following edge (back-to-back allowed when done=1).
- Multiply: shift-add over a 64-bit product. {hi,lo} = full 64-bit product.
  - Signed product is negated (two's complement, 64-bit) if the operand signs differ.
- Divide: restoring, 1 quotient bit per cycle. lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (rt_data=0, DIV or DIVU): hi=rs_data (original, unsigned-interpreted raw bits), lo=32'hFFFFFFFF. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
- start while busy=1: ignored; operands not re-latched.
- hi_we/lo_we in IDLE: register written at that edge. While busy (CALC or FIXUP): ignored, no change.
- start and hi_we/lo_we on the same IDLE edge: the MT write is applied; the operation later overwrites both hi and lo at FIXUP.
- hi/lo hold their values in all other cycles. hi/lo must not show intermediate values during CALC: use internal accumulators only.
- op is sampled only at accept; changes during CALC have no effect.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle combinational 64-bit multiply.
  - Accept at E0 -> FIXUP at E1: hi/lo written, done=1, busy high for exactly one cycle.
  - DIV/DIVU unchanged (33 edges).
- Undefined: all four ops take the iterative 33-edge path.
- Results are bit-identical in both builds.

Test Plan:
1. Reset low, release; start MULT rs=0xFFFFFFFE, rt=0x00000003 -> busy 1 for 33 cycles, done pulse once; hi=0xFFFFFFFF, lo=0xFFFFFFFA. With MDU_FAST_MUL_EN: done after 1 cycle, same values.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands -> hi=0, lo=1.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
4. DIVU 7/0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Start DIVU 100/7. At cycle 5 pulse start (MULT 2×2) and hi_we with wr_data=0xDEAD -> both ignored; final lo=14, hi=2. Afterwards hi_we with 0x1234 in IDLE -> hi=0x1234, lo unchanged.
6. Start MULT 5×5; drive Reset=0 at cycle 10 -> immediately hi=lo=0, busy=0, done=0. Release reset; start MULTU 5×5 -> lo=25, hi=0 after full latency.
